// File: rtl/maxnet_winner_tracker_pkg.sv
// Shared types for the MaxNet winner tracker:
// status codes, FSM states, width helper.
package maxnet_winner_tracker_pkg;

  typedef enum logic [1:0] {
    ST_NONE     = 2'd0,
    ST_WIN      = 2'd1,
    ST_ALL_ZERO = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/maxnet_winner_tracker_classify.sv
// Combinational survivor analysis of one
// activation vector (sign bit ignored).
module winner_classify
  import maxnet_winner_tracker_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
  input  logic [N_CH*DATA_W-1:0] acts,
  output logic                   any_nz,
  output logic                   multi_nz,
  output logic [IDX_W-1:0]       first_idx
);

  logic [N_CH-1:0] nz;

  // per-channel nonzero flag on magnitude bits only
  always_comb begin
    nz = '0;
    for (int k = 0; k < N_CH; k++)
      nz[k] = |acts[k*DATA_W +: DATA_W-1];
  end

  // count survivors and pick the lowest-index one
  always_comb begin
    any_nz    = 1'b0;
    multi_nz  = 1'b0;
    first_idx = '0;
    for (int k = N_CH-1; k >= 0; k--)
      if (nz[k]) first_idx = IDX_W'(k);
    for (int k = 0; k < N_CH; k++) begin
      multi_nz = multi_nz | (any_nz & nz[k]);
      any_nz   = any_nz | nz[k];
    end
  end

endmodule

// File: rtl/maxnet_winner_tracker.sv
// Sequential MaxNet winner tracker: iterates until
// one survivor, all-zero or timeout; holds until ack.
module maxnet_winner_tracker
  import maxnet_winner_tracker_pkg::*;
#(
  parameter  int N_CH     = 4,
  parameter  int DATA_W   = 32,
  parameter  int MAX_ITER = 64,
  localparam int IDX_W    = (clog2(N_CH) > 1) ? clog2(N_CH) : 1,
  localparam int ITER_W   = clog2(MAX_ITER+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [N_CH*DATA_W-1:0] acts,
  input  logic                   ack,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       idx,
  output logic [1:0]             status,
  output logic [ITER_W-1:0]      iter_cnt
);

  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER-1);

  state_t            state;
  status_t           stat_q;
  logic              any_nz;
  logic              multi_nz;
  logic [IDX_W-1:0]  first_idx;
  logic [ITER_W-1:0] iter_nxt;

  winner_classify #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W)
  ) u_classify (
    .acts      (acts),
    .any_nz    (any_nz),
    .multi_nz  (multi_nz),
    .first_idx (first_idx)
  );

  assign status = stat_q;

  // saturating iteration count for the next sample
  always_comb begin
    iter_nxt = iter_cnt;
    if (iter_cnt != ITER_MAX)
      iter_nxt = iter_cnt + 1'b1;
  end

  // control FSM with registered result fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      idx      <= '0;
      stat_q   <= ST_NONE;
      iter_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            iter_cnt <= '0;
          end
        end
        RUN: begin
          if (start) begin
            iter_cnt <= '0;
          end else if (in_valid) begin
            iter_cnt <= iter_nxt;
            if (!any_nz) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              idx    <= '0;
              stat_q <= ST_ALL_ZERO;
            end else if (!multi_nz) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              idx    <= first_idx;
              stat_q <= ST_WIN;
            end else if (iter_cnt == ITER_LAST) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              idx    <= first_idx;
              stat_q <= ST_TIMEOUT;
            end
          end
        end
        DONE: begin
          if (ack && start) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            iter_cnt <= '0;
          end else if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/maxnet_winner_tracker.md
Name: maxnet_winner_tracker

Overview:
- Sequential, parametrised successor to the combinational one-hot winner decoder at the output of the MaxNet layer.
- Per classification: accepts one activation vector per MaxNet iteration.
- Detects exactly-one-survivor, all-zero or iteration-timeout.
- Latches the result with a status code and holds it until the controller acknowledges.

Parameters:
- N_CH, 4: number of competing neurons/channels (>=2).
- DATA_W, 32: activation word width; MSB is the sign bit (IEEE-754 single at default).
- MAX_ITER, 64: maximum iterations before forced TIMEOUT (>=1).
- Derived localparams (not overridable): IDX_W = max(1, clog2(N_CH)); ITER_W = clog2(MAX_ITER+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin or restart a classification.
- in_valid  in  1  acts holds one iteration result this cycle.
- acts  in  N_CH*DATA_W  packed activations; channel k at [k*DATA_W +: DATA_W].
- ack  in  1  controller consumed result.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; result fields stable.
- idx  out  IDX_W  winner index.
- status  out  2  result code.
- iter_cnt  out  ITER_W  in-valid samples consumed in the current or last run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, idx=0, status=NONE, iter_cnt=0.
- Zero test per channel: magnitude bits [DATA_W-2:0] all zero; sign ignored, so +0 and -0 are both zero.
- States:
  - IDLE -> RUN on start: iter_cnt<=0, busy<=1. in_valid in IDLE is ignored.
  - RUN, start=1 (regardless of in_valid): restart; iter_cnt<=0, the sample is discarded, stay in RUN.
  - RUN, in_valid=1, start=0, classify the sample:
    - Exactly one nonzero channel k -> DONE: idx=k, status=WIN.
    - No nonzero channel -> DONE: idx=0, status=ALL_ZERO.
    - Two or more nonzero channels, iter_cnt+1 == MAX_ITER -> DONE: status=TIMEOUT, idx=lowest-index nonzero channel.
    - Two or more nonzero channels otherwise -> stay in RUN.
    - In every case iter_cnt increments by 1 (saturates at MAX_ITER).
  - RUN, in_valid=0 -> hold.
  - DONE: done=1, busy=0; idx/status/iter_cnt frozen; in_valid ignored.
    - ack=1 -> IDLE (done<=0; idx/status/iter_cnt keep last values).
    - ack=1 and start=1 in the same cycle -> RUN directly (iter_cnt<=0).
    - start without ack -> ignored.
- Latency: done rises on the clock edge that samples the deciding in_valid (registered; visible the next cycle). One sample is accepted per cycle; back-to-back in_valid is allowed.
- ack outside DONE is ignored.
- Async reset mid-RUN or mid-DONE returns to the reset state immediately; no partial result is retained.
- All outputs are registered; no combinational path from inputs to outputs.
- MAX_ITER=1 corner: the first sample with two or more nonzeros gives TIMEOUT with iter_cnt=1.

Decomposition:
- Shared package / include file:
  - Status codes: NONE=2'd0, WIN=2'd1, ALL_ZERO=2'd2, TIMEOUT=2'd3.
  - FSM state encodings IDLE/RUN/DONE.
  - clog2 function.
- One sub-module: winner_classify. Purely combinational, parametrised by N_CH and DATA_W.
  - Input: acts.
  - Outputs: any_nz, multi_nz, first_idx (lowest nonzero index).
  - Computes per-channel zero flags; the parent instantiates it once.

Test Plan:
- Reset/idle (N_CH=4, DATA_W=32): release rst_n, pulse in_valid with arbitrary acts -> busy=0, done=0, status=NONE, iter_cnt=0.
- Convergence: start; then 3 samples {1.0,0.5,0.25,0}, {0.7,0.2,0,0}, {0,32'h3F000000,0,32'h80000000} -> done after 3rd sample, idx=1, status=WIN, iter_cnt=3 (-0 on ch3 counts as zero); ack -> IDLE with idx=1 retained.
- All-zero: start; sample {0,32'h80000000,0,0} -> done, status=ALL_ZERO, idx=0, iter_cnt=1.
- Timeout (MAX_ITER=4): start; 4 samples all {1.0,1.0,0,1.0} -> done on 4th, status=TIMEOUT, idx=0, iter_cnt=4; a 5th in_valid in DONE changes nothing.
- Restart/ack-start: mid-RUN after 2 samples assert start with in_valid -> iter_cnt=0, sample discarded. In DONE, ack+start same cycle -> busy=1, done=0 next cycle.
- Async reset mid-run: rst_n low for a half cycle during RUN -> all outputs at reset values immediately; a later start begins a fresh run with iter_cnt=0.
